// File: rtl/lsb_mem_port_pkg.sv
// rtl/lsb_mem_port_pkg.sv - shared encodings and helpers for the LSB memory responder
package lsb_mem_port_pkg;

    // Default widths (addrWidth / dataWidth)
    localparam int ADDR_WIDTH_DFLT = 32;
    localparam int DATA_WIDTH_DFLT = 32;

    // Request size encodings; 2'b11 is reserved and behaves as a word
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    // addr[17:16] value that selects the UART I/O region
    localparam logic [1:0] IO_REGION_HI = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Number of bytes moved for a request size
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsb_mem_port_load_extend.sv
// rtl/lsb_mem_port_load_extend.sv - sign/zero extension of assembled load data
module lsb_mem_port_load_extend
    import lsb_mem_port_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] ext_o
);

    // Keep the low N bytes and fill the rest with the sign bit or zeros
    always_comb begin
        ext_o = word_i;
        case (size_i)
            SIZE_B:  ext_o = {{24{signed_i & word_i[7]}}, word_i[7:0]};
            SIZE_H:  ext_o = {{16{signed_i & word_i[15]}}, word_i[15:0]};
            default: ext_o = word_i;
        endcase
    end

endmodule

// File: rtl/lsb_mem_port.sv
// rtl/lsb_mem_port.sv - serialises LSB load/store requests onto a byte-wide RAM port
module lsb_mem_port
    import lsb_mem_port_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic                  clear,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full
);

    state_e                state_q, state_d;
    logic [2:0]            k_q, k_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           bytes_q, bytes_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [7:0]            mem_dout_q, mem_dout_d;
    logic                  wr_q, wr_d;

    logic [2:0]  n_bytes;
    logic [2:0]  k_inc;
    logic [1:0]  cap_idx;
    logic [31:0] cap_word;
    logic [31:0] ext_word;
    logic        io_stall;
    logic        wr_fire;

    assign n_bytes  = size_bytes(size_q);
    assign k_inc    = k_q + 3'd1;
    // Byte k-1 arrives while the counter reads k (RAM has one cycle of latency)
    assign cap_idx  = k_q[1:0] - 2'd1;
    assign io_stall = io_buffer_full & (addr_q[17:16] == IO_REGION_HI);
    // wr_q is only ever set in WRITE, so this is "a store byte lands this cycle"
    assign wr_fire  = wr_q & ~io_stall;

    assign req_ready  = (state_q == ST_IDLE) & ~clear;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign mem_a      = mem_a_q;
    assign mem_dout   = mem_dout_q;
    // The write strobe is gated live so a freeze or a full UART never sees a write
    assign mem_wr     = wr_fire & rdy;

    // Merge the byte currently on mem_din into the partially assembled word
    always_comb begin
        cap_word = bytes_q;
        cap_word[{cap_idx, 3'b000} +: 8] = mem_din;
    end

    lsb_mem_port_load_extend u_load_extend (
        .word_i   (cap_word),
        .size_i   (size_q),
        .signed_i (signed_q),
        .ext_o    (ext_word)
    );

    // Next-state and registered-output logic for the IDLE/READ/WRITE sequencer
    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        addr_d       = addr_q;
        size_d       = size_q;
        signed_d     = signed_q;
        wdata_d      = wdata_q;
        bytes_d      = bytes_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        mem_a_d      = mem_a_q;
        mem_dout_d   = mem_dout_q;
        wr_d         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    addr_d   = req_addr;
                    size_d   = req_size;
                    signed_d = req_signed;
                    wdata_d  = req_wdata[31:0];
                    bytes_d  = 32'd0;
                    k_d      = 3'd0;
                    mem_a_d  = req_addr;
                    if (req_is_store) begin
                        state_d    = ST_WRITE;
                        mem_dout_d = req_wdata[7:0];
                        wr_d       = 1'b1;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end

            ST_READ: begin
                if (clear) begin
                    state_d = ST_IDLE;
                    k_d     = 3'd0;
                end else begin
                    if (k_q != 3'd0) begin
                        bytes_d = cap_word;
                    end
                    if (k_q == n_bytes) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = DATA_WIDTH'(ext_word);
                        state_d      = ST_IDLE;
                        k_d          = 3'd0;
                    end else begin
                        k_d = k_inc;
                        if (k_inc < n_bytes) begin
                            mem_a_d = addr_q + ADDR_WIDTH'(k_inc);
                        end
                    end
                end
            end

            ST_WRITE: begin
                // clear is deliberately ignored: a committed store must retire
                wr_d = wr_q;
                if (wr_fire) begin
                    if (k_q == n_bytes - 3'd1) begin
                        resp_valid_d = 1'b1;
                        resp_data_d  = '0;
                        state_d      = ST_IDLE;
                        k_d          = 3'd0;
                        wr_d         = 1'b0;
                    end else begin
                        k_d        = k_inc;
                        mem_a_d    = addr_q + ADDR_WIDTH'(k_inc);
                        mem_dout_d = wdata_q[{k_inc[1:0], 3'b000} +: 8];
                        wr_d       = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                k_d     = 3'd0;
            end
        endcase
    end

    // State register; rdy low freezes everything so the pending RAM byte is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            k_q          <= 3'd0;
            addr_q       <= '0;
            size_q       <= SIZE_W;
            signed_q     <= 1'b0;
            wdata_q      <= 32'd0;
            bytes_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            mem_a_q      <= '0;
            mem_dout_q   <= 8'd0;
            wr_q         <= 1'b0;
        end else if (rdy) begin
            state_q      <= state_d;
            k_q          <= k_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            wdata_q      <= wdata_d;
            bytes_q      <= bytes_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            mem_a_q      <= mem_a_d;
            mem_dout_q   <= mem_dout_d;
            wr_q         <= wr_d;
        end
    end

endmodule

// File: tb/tb_lsb_mem_port.sv
// tb/tb_lsb_mem_port.sv - directed vector bench for lsb_mem_port
module tb_lsb_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        clear;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ram [int unsigned];

    typedef struct {
        logic        st;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    lsb_mem_port #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_is_store   (req_is_store),
        .req_size       (req_size),
        .req_signed     (req_signed),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .clear          (clear),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    // Synchronous RAM that also freezes while rdy is low
    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr) ram[mem_a] = mem_dout;
            mem_din <= rd(mem_a);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        req_is_store = st;
        req_size     = sz;
        req_signed   = sg;
        req_addr     = a;
        req_wdata    = wd;
        req_valid    = 1'b1;
        #1;
        chk("req_ready before accept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int start, output int cyc);
        cyc = start;
        while (resp_valid !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        vecs[0]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0100, 32'h0000_0080, 32'hFFFF_FF80, 3};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0000_0080, 32'h0000_0080, 3};
        vecs[2]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h4433_2211, 32'h4433_2211, 6};
        vecs[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0301, 32'h0000_F234, 32'hFFFF_F234, 4};
        vecs[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0301, 32'h0000_F234, 32'h0000_F234, 4};
        vecs[5]  = '{1'b0, 2'b11, 1'b1, 32'h0000_0500, 32'h8403_0201, 32'h8403_0201, 6};
        vecs[6]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0600, 32'h0000_7F12, 32'h0000_7F12, 4};
        vecs[7]  = '{1'b0, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h0000_55AA, 32'h0000_55AA, 4};
        vecs[8]  = '{1'b1, 2'b01, 1'b0, 32'h0000_03FF, 32'hABCD_1234, 32'h0000_0000, 3};
        vecs[9]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0700, 32'hDEAD_BEEF, 32'h0000_0000, 5};
        vecs[10] = '{1'b1, 2'b00, 1'b0, 32'h0000_0800, 32'h1234_565A, 32'h0000_0000, 2};

        rst = 1'b1; rdy = 1'b1; req_valid = 1'b0; req_is_store = 1'b0;
        req_size = 2'b00; req_signed = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        clear = 1'b0; io_buffer_full = 1'b0;
        tick(); tick();
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_data", resp_data, 32'd0);
        chk("reset mem_a", mem_a, 32'd0);
        chk("reset mem_dout", 32'(mem_dout), 32'd0);
        chk("reset mem_wr", 32'(mem_wr), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick();

        // Table-driven single requests
        for (int i = 0; i < 11; i++) begin
            int nb;
            nb = nbytes(vecs[i].sz);
            if (!vecs[i].st) begin
                for (int b = 0; b < 4; b++) ram[32'(vecs[i].addr + 32'(b))] = vecs[i].data[8*b +: 8];
            end else begin
                ram[32'(vecs[i].addr + 32'(nb))] = 8'hEE;
            end
            issue(vecs[i].st, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].data);
            wait_resp(1, lat);
            chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d resp_data", i), resp_data, vecs[i].exp);
            chk($sformatf("vec%0d req_ready in resp cycle", i), 32'(req_ready), 32'd1);
            if (vecs[i].st) begin
                for (int b = 0; b < nb; b++)
                    chk($sformatf("vec%0d ram byte %0d", i, b),
                        32'(rd(32'(vecs[i].addr + 32'(b)))), 32'(vecs[i].data[8*b +: 8]));
                chk($sformatf("vec%0d guard byte", i),
                    32'(rd(32'(vecs[i].addr + 32'(nb)))), 32'h0000_00EE);
            end
            tick();
        end

        // LW address stepping, then a back-to-back LBU issued in the response cycle
        issue(1'b0, 2'b10, 1'b0, 32'h200, 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("lw mem_a step %0d", i), mem_a, 32'h200 + 32'(i));
            chk($sformatf("lw mem_wr step %0d", i), 32'(mem_wr), 32'd0);
            if (i < 3) tick();
        end
        wait_resp(4, lat);
        chk("lw step latency", 32'(lat), 32'd6);
        chk("lw step data", resp_data, 32'h4433_2211);
        issue(1'b0, 2'b00, 1'b0, 32'h100, 32'd0);
        wait_resp(1, lat);
        chk("back-to-back lbu latency", 32'(lat), 32'd3);
        chk("back-to-back lbu data", resp_data, 32'h0000_0080);
        tick();

        // Store to the I/O region stalls while the UART buffer is full
        ram[32'h30000] = 8'h00;
        io_buffer_full = 1'b1;
        issue(1'b1, 2'b00, 1'b0, 32'h30000, 32'h0000_0077);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("io stall mem_wr %0d", i), 32'(mem_wr), 32'd0);
            tick();
        end
        io_buffer_full = 1'b0;
        #1;
        chk("io write mem_wr", 32'(mem_wr), 32'd1);
        chk("io write mem_a", mem_a, 32'h30000);
        chk("io write mem_dout", 32'(mem_dout), 32'h77);
        tick();
        chk("io resp_valid", 32'(resp_valid), 32'd1);
        chk("io ram byte", 32'(rd(32'h30000)), 32'h77);
        tick();

        // Outside the I/O region a full UART buffer does not stall
        io_buffer_full = 1'b1;
        issue(1'b1, 2'b00, 1'b0, 32'h20000, 32'h0000_0066);
        wait_resp(1, lat);
        chk("non-io store latency", 32'(lat), 32'd2);
        chk("non-io ram byte", 32'(rd(32'h20000)), 32'h66);
        io_buffer_full = 1'b0;
        tick();

        // Word load flushed at T+2: no response, idle at T+3
        for (int b = 0; b < 4; b++) ram[32'h0C00 + 32'(b)] = 8'h10 + 8'(b);
        issue(1'b0, 2'b10, 1'b0, 32'hC00, 32'd0);
        tick();
        clear = 1'b1;
        #1;
        chk("clear req_ready low", 32'(req_ready), 32'd0);
        tick();
        clear = 1'b0;
        #1;
        chk("clear no resp_valid", 32'(resp_valid), 32'd0);
        chk("clear idle at T+3", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        chk("clear no late resp", 32'(seen), 32'd0);

        // clear in IDLE blocks acceptance
        req_is_store = 1'b0; req_size = 2'b00; req_addr = 32'h100;
        req_valid = 1'b1; clear = 1'b1;
        #1;
        chk("idle clear req_ready", 32'(req_ready), 32'd0);
        tick();
        req_valid = 1'b0; clear = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (resp_valid) seen++;
        end
        chk("idle clear not accepted", 32'(seen), 32'd0);

        // Word store ignores clear at T+2 and completes
        ram[32'h904] = 8'hEE;
        issue(1'b1, 2'b10, 1'b0, 32'h900, 32'hCAFE_F00D);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wait_resp(3, lat);
        chk("store clear latency", 32'(lat), 32'd5);
        chk("store clear data", {rd(32'h903), rd(32'h902), rd(32'h901), rd(32'h900)}, 32'hCAFE_F00D);
        chk("store clear guard", 32'(rd(32'h904)), 32'hEE);
        tick();

        // rdy low during a store suppresses mem_wr and delays completion
        ram[32'hD00] = 8'h00;
        issue(1'b1, 2'b00, 1'b0, 32'hD00, 32'h0000_0099);
        rdy = 1'b0;
        #1;
        chk("rdy low mem_wr", 32'(mem_wr), 32'd0);
        tick(); tick();
        rdy = 1'b1;
        #1;
        chk("rdy back mem_wr", 32'(mem_wr), 32'd1);
        wait_resp(3, lat);
        chk("rdy store latency", 32'(lat), 32'd4);
        chk("rdy store ram", 32'(rd(32'hD00)), 32'h99);
        tick();

        // rdy low for 2 cycles mid word load delays the result by 2
        ram[32'hA00] = 8'hC0; ram[32'hA01] = 8'hD0; ram[32'hA02] = 8'hE0; ram[32'hA03] = 8'hF0;
        issue(1'b0, 2'b10, 1'b0, 32'hA00, 32'd0);
        tick();
        rdy = 1'b0;
        tick(); tick();
        rdy = 1'b1;
        wait_resp(4, lat);
        chk("rdy load latency", 32'(lat), 32'd8);
        chk("rdy load data", resp_data, 32'hF0E0_D0C0);

        // Reset mid word store drops the request
        ram[32'hB02] = 8'hEE; ram[32'hB03] = 8'hEE;
        issue(1'b1, 2'b10, 1'b0, 32'hB00, 32'h0102_0304);
        tick();
        rst = 1'b1;
        tick();
        chk("rst mem_wr", 32'(mem_wr), 32'd0);
        chk("rst resp_valid", 32'(resp_valid), 32'd0);
        chk("rst resp_data", resp_data, 32'd0);
        chk("rst mem_a", mem_a, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst idle req_ready", 32'(req_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (resp_valid || mem_wr) seen++;
        end
        chk("rst no activity after", 32'(seen), 32'd0);
        chk("rst dropped byte 2", 32'(rd(32'hB02)), 32'hEE);
        chk("rst dropped byte 3", 32'(rd(32'hB03)), 32'hEE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
